if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have port clk, input, 1, system clock.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port jtag_reset_flag_i, input, 1, debug reset; behaves as flush.
REQ-004 SHALL have port flow_if_i, input, FLOW_WIDTH, flow command; encodings FLOW_WORK, FLOW_STOP, FLOW_REFRESH from the team defines.
REQ-005 SHALL have port curr_pc_i, input, CPU_WIDTH, current pc from the pc register.
REQ-006 SHALL have port fetch_stall_o, output, 1, pc must hold this cycle.
REQ-007 SHALL have ports ibus_req_o (output, 1), ibus_addr_o (output, CPU_WIDTH), ibus_gnt_i (input, 1), ibus_rvalid_i (input, 1) and ibus_rdata_i (input, 32), forming the instruction bus.
REQ-008 SHALL have ports inst_valid_o (output, 1), inst_o (output, 32) and inst_addr_o (output, CPU_WIDTH), carrying the decode-side instruction.
REQ-009 SHALL have port id_ready_i, input, 1, decode accepts the instruction.

Function
REQ-010 SHALL hold at most one bus transaction outstanding.
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT and DROP.
REQ-012 IDLE -> REQ when flow_if_i==FLOW_WORK, no flush and buffer count + outstanding < 2.
REQ-013 In REQ: ibus_req_o=1 and ibus_addr_o=curr_pc_i; address held stable until grant; on ibus_gnt_i latch address and go to WAIT.
REQ-014 In WAIT, on ibus_rvalid_i: push {latched addr, ibus_rdata_i} into buffer; next state REQ if REQ-012 conditions hold (evaluated with post-push count), else IDLE.
REQ-015 fetch_stall_o SHALL equal ~(ibus_req_o & ibus_gnt_i), so the pc advances only in the grant cycle.
REQ-016 Instruction buffer: 2-entry FIFO of {addr, inst}; inst_valid_o = count!=0; inst_o/inst_addr_o = head entry; pop when inst_valid_o & id_ready_i.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged; push into full buffer is impossible by REQ-012 and is an assertion error.
REQ-018 Response-to-inst_valid_o latency SHALL be 1 cycle (registered push); no combinational rdata->inst_o path.
REQ-019 Flush = flow_if_i==FLOW_REFRESH or jtag_reset_flag_i: buffer emptied next cycle; REQ not yet granted -> IDLE with req dropped; REQ granted this cycle or WAIT without rvalid -> DROP; WAIT with rvalid this cycle -> response discarded, IDLE.
REQ-020 DROP: ibus_req_o=0; on ibus_rvalid_i discard data, go IDLE; further flushes keep DROP.
REQ-021 flow_if_i==FLOW_STOP: no new request leaves IDLE; REQ stays asserted until granted; WAIT completes normally; buffer keeps contents and still drains to decode.
REQ-022 Flush SHALL take priority over push, pop and state advance in the same cycle.
REQ-023 Unknown flow_if_i encodings SHALL be treated as FLOW_REFRESH.

Reset
REQ-024 On rst_n low, asynchronously: state IDLE, count 0, ibus_req_o=0, ibus_addr_o=0, inst_valid_o=0, inst_o=0, inst_addr_o=0, fetch_stall_o=1.
REQ-025 Reset deassertion mid-transaction SHALL NOT wait for or consume a pending rvalid; the bus is assumed reset together.
REQ-026 First request SHALL be issued no earlier than the second clk edge after rst_n rises.

Verification
REQ-027 Zero-wait bus, id_ready_i=1, WORK, pc 0,4,8: requests at 0x0,0x4,0x8; inst_o sequence matches rdata with inst_addr_o 0x0,0x4,0x8; fetch_stall_o low only in grant cycles.
REQ-028 gnt delayed 3 cycles at pc 0x10: ibus_addr_o stays 0x10, fetch_stall_o=1 for 3 cycles, then 0 for one cycle.
REQ-029 id_ready_i=0 for 10 cycles: exactly 2 instructions buffered, ibus_req_o=0 afterwards, inst_o holds head; on release, in-order drain then requests resume.
REQ-030 FLOW_REFRESH in WAIT at addr 0x20, rvalid 2 cycles later with 0xDEADBEEF: inst_valid_o never shows 0xDEADBEEF; next request is to the new curr_pc_i (0x0).
REQ-031 Push and pop in same cycle with count=1: count stays 1, new head is the pushed entry, no bubble on inst_valid_o.
REQ-032 rst_n low while in WAIT: all outputs at REQ-024 values immediately, before next clk edge.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: one-outstanding instruction bus master
// feeding a 2-entry {addr, inst} buffer towards decode.
module if_fetch #(
  parameter int CPU_WIDTH  = 32,
  parameter int FLOW_WIDTH = 2,
  parameter logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'd0,
  parameter logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'd1,
  parameter logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jtag_reset_flag_i,
  input  logic [FLOW_WIDTH-1:0] flow_if_i,
  input  logic [CPU_WIDTH-1:0]  curr_pc_i,
  output logic                  fetch_stall_o,
  output logic                  ibus_req_o,
  output logic [CPU_WIDTH-1:0]  ibus_addr_o,
  input  logic                  ibus_gnt_i,
  input  logic                  ibus_rvalid_i,
  input  logic [31:0]           ibus_rdata_i,
  output logic                  inst_valid_o,
  output logic [31:0]           inst_o,
  output logic [CPU_WIDTH-1:0]  inst_addr_o,
  input  logic                  id_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]           cnt_q;
  logic [1:0]           cnt_post;
  logic                 rd_q;
  logic                 wr_q;
  logic [CPU_WIDTH-1:0] addr_buf_q [2];
  logic [31:0]          inst_buf_q [2];
  logic [CPU_WIDTH-1:0] lat_addr_q;
  logic                 boot_q;

  logic flow_work;
  logic flow_stop;
  logic flush;
  logic can_req;
  logic push;
  logic pop;
  logic grant;

  // Unknown flow encodings fall into flush
  assign flow_work = (flow_if_i == FLOW_WORK);
  assign flow_stop = (flow_if_i == FLOW_STOP);
  assign flush     = jtag_reset_flag_i
                   | ~(flow_work | flow_stop);

  assign can_req = flow_work & ~flush & boot_q;

  assign ibus_req_o    = (state_q == REQ);
  assign ibus_addr_o   = ibus_req_o ? curr_pc_i : '0;
  assign grant         = ibus_req_o & ibus_gnt_i;
  assign fetch_stall_o = ~grant;

  assign inst_valid_o = (cnt_q != 2'd0);
  assign inst_o       = inst_buf_q[rd_q];
  assign inst_addr_o  = addr_buf_q[rd_q];

  assign pop  = inst_valid_o & id_ready_i;
  assign push = (state_q == WAIT)
              & ibus_rvalid_i & ~flush;

  assign cnt_post = cnt_q + 2'd1 - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (can_req && cnt_q < 2'd2)
          state_d = REQ;
      end
      REQ: begin
        if (flush)
          state_d = ibus_gnt_i ? DROP : IDLE;
        else if (ibus_gnt_i)
          state_d = WAIT;
      end
      WAIT: begin
        if (flush)
          state_d = ibus_rvalid_i ? IDLE : DROP;
        else if (ibus_rvalid_i)
          state_d = (can_req && cnt_post < 2'd2)
                  ? REQ : IDLE;
      end
      DROP: begin
        if (ibus_rvalid_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // boot_q delays the first request by one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      boot_q     <= 1'b0;
      lat_addr_q <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b1;
      if (grant)
        lat_addr_q <= curr_pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_buf_q[i] <= '0;
        inst_buf_q[i] <= '0;
      end
    end else if (flush) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      if (push) begin
        addr_buf_q[wr_q] <= lat_addr_q;
        inst_buf_q[wr_q] <= ibus_rdata_i;
        wr_q             <= ~wr_q;
      end
      if (pop)
        rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && cnt_q == 2'd2)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: bus responder, pc model and
// scoreboard of expected {addr, inst} pairs.
module tb_if_fetch;

  localparam logic [1:0] FW = 2'd0;
  localparam logic [1:0] FS = 2'd1;
  localparam logic [1:0] FR = 2'd2;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        jtag = 1'b0;
  logic [1:0]  flow = FS;
  logic [31:0] pc = '0;
  logic        stall;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        id_ready = 1'b0;

  if_fetch #(
    .CPU_WIDTH(32), .FLOW_WIDTH(2),
    .FLOW_WORK(FW), .FLOW_STOP(FS),
    .FLOW_REFRESH(FR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .jtag_reset_flag_i(jtag),
    .flow_if_i(flow),
    .curr_pc_i(pc),
    .fetch_stall_o(stall),
    .ibus_req_o(req),
    .ibus_addr_o(addr),
    .ibus_gnt_i(gnt),
    .ibus_rvalid_i(rvalid),
    .ibus_rdata_i(rdata),
    .inst_valid_o(valid),
    .inst_o(inst),
    .inst_addr_o(inst_addr),
    .id_ready_i(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] gnt_q [$];
  int          checks = 0;
  int          errors = 0;
  int          gnt_delay = 0;
  int          rsp_delay = 1;
  bit          force_bad = 0;
  bit          pending = 0;
  int          rsp_cnt = 0;
  int          wait_cnt = 0;
  logic [31:0] rsp_addr = '0;
  bit          adv = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h13;
  endfunction

  // Bus responder, pc model and scoreboard monitor
  initial begin
    exp_t e;
    bit   fl;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gnt = 0; rvalid = 0; pending = 0;
        wait_cnt = 0; adv = 0;
        continue;
      end
      if (adv) pc = pc + 32'd4;
      adv = 0;
      gnt = 0;
      if (req) begin
        if (wait_cnt >= gnt_delay) gnt = 1;
        else wait_cnt++;
      end else wait_cnt = 0;
      rvalid = 0;
      if (pending) begin
        if (rsp_cnt == 0) begin
          rvalid = 1; pending = 0;
          if (force_bad) begin
            rdata = BAD; force_bad = 0;
          end else begin
            rdata = mem(rsp_addr);
            e.a = rsp_addr; e.d = rdata;
            exp_q.push_back(e);
          end
        end else rsp_cnt--;
      end
      #3;
      if (!rst_n) continue;
      checks++;
      if (stall !== ~(req & gnt)) begin
        errors++;
        $display("FAIL stall got %b want %b",
                 stall, ~(req & gnt));
      end
      if (req && gnt) begin
        checks++;
        if (pending) begin
          errors++;
          $display("FAIL outstanding got 2 want 1");
        end
        pending = 1; rsp_cnt = rsp_delay - 1;
        rsp_addr = addr; gnt_q.push_back(addr);
        adv = 1; wait_cnt = 0;
      end
      if (valid) begin
        checks++;
        if (inst === BAD) begin
          errors++;
          $display("FAIL dropped_data got %h want not %h",
                   inst, BAD);
        end
      end
      fl = jtag || (flow != FW && flow != FS);
      if (valid && id_ready && !fl) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty got %h@%h want none",
                   inst, inst_addr);
        end else begin
          e = exp_q.pop_front();
          if (inst !== e.d || inst_addr !== e.a) begin
            errors++;
            $display("FAIL sb got %h@%h want %h@%h",
                     inst, inst_addr, e.d, e.a);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic quiesce();
    int n;
    flow = FS;
    id_ready = 1;
    for (n = 0; n < 80; n++) begin
      step();
      if (!req && !pending && !valid
          && exp_q.size() == 0) break;
    end
    checks++;
    if (n == 80) begin
      errors++;
      $display("FAIL quiesce got timeout want idle");
    end
    gnt_q.delete();
  endtask

  task automatic test_reset();
    #3 rst_n = 0;
    #1;
    checks += 6;
    if (req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b want 0", req);
    end
    if (addr !== 32'h0) begin
      errors++; $display("FAIL rst_addr got %h want 0", addr);
    end
    if (valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b want 0", valid);
    end
    if (inst !== 32'h0) begin
      errors++; $display("FAIL rst_inst got %h want 0", inst);
    end
    if (inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_iaddr got %h want 0", inst_addr);
    end
    if (stall !== 1'b1) begin
      errors++; $display("FAIL rst_stall got %b want 1", stall);
    end
    step();
    step();
    pc = 32'h0; flow = FW; id_ready = 1;
    rst_n = 1;
    step();
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL first_req_early got %b want 0", req);
    end
  endtask

  task automatic test_basic();
    bit seen = 0;
    for (int n = 0; n < 40 && gnt_q.size() < 3; n++) begin
      if (rvalid && !seen) begin
        seen = 1;
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL rsp_latency got %b want 0", valid);
        end
      end
      step();
    end
    checks++;
    if (gnt_q.size() < 3) begin
      errors++;
      $display("FAIL basic_grants got %0d want 3",
               gnt_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (gnt_q[i] !== 32'(i * 4)) begin
          errors++;
          $display("FAIL basic_addr got %h want %h",
                   gnt_q[i], 32'(i * 4));
        end
      end
    end
    quiesce();
  endtask

  task automatic test_gnt_delay();
    int n;
    pc = 32'h10; gnt_delay = 3; flow = FW;
    for (n = 0; n < 10; n++) begin
      step();
      if (req) break;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (req !== 1 || addr !== 32'h10 || stall !== 1) begin
        errors++;
        $display("FAIL gnt_wait got %b/%h/%b want 1/10/1",
                 req, addr, stall);
      end
      step();
    end
    checks++;
    if (addr !== 32'h10 || stall !== 0) begin
      errors++;
      $display("FAIL gnt_cycle got %h/%b want 10/0",
               addr, stall);
    end
    flow = FS; gnt_delay = 0;
    quiesce();
  endtask

  task automatic test_backpressure();
    id_ready = 0; pc = 32'h100; flow = FW;
    repeat (10) step();
    checks += 4;
    if (valid !== 1 || req !== 0) begin
      errors++;
      $display("FAIL bp_state got %b/%b want 1/0", valid, req);
    end
    if (gnt_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL bp_count got %0d/%0d want 2/2",
               gnt_q.size(), exp_q.size());
    end
    if (inst_addr !== 32'h100) begin
      errors++;
      $display("FAIL bp_head_addr got %h want 100", inst_addr);
    end
    if (inst !== mem(32'h100)) begin
      errors++;
      $display("FAIL bp_head got %h want %h",
               inst, mem(32'h100));
    end
    id_ready = 1;
    for (int n = 0; n < 20 && gnt_q.size() < 3; n++) step();
    checks++;
    if (gnt_q.size() < 3 || gnt_q[2] !== 32'h108) begin
      errors++;
      $display("FAIL bp_resume got %0d grants want 108",
               gnt_q.size());
    end
    quiesce();
  endtask

  task automatic test_flush();
    pc = 32'h20; rsp_delay = 3; force_bad = 1;
    id_ready = 1; flow = FW;
    for (int n = 0; n < 10 && gnt_q.size() < 1; n++) step();
    step();
    flow = FR; pc = 32'h0;
    step();
    flow = FW;
    for (int n = 0; n < 30 && gnt_q.size() < 2; n++) step();
    checks += 2;
    if (force_bad !== 0) begin
      errors++;
      $display("FAIL flush_rsp got pending want delivered");
    end
    if (gnt_q.size() < 2 || gnt_q[1] !== 32'h0) begin
      errors++;
      $display("FAIL flush_newpc got %0d grants want addr 0",
               gnt_q.size());
    end
    rsp_delay = 1;
    quiesce();
  endtask

  task automatic test_same_cycle();
    bit hit = 0;
    pc = 32'h200; id_ready = 0; flow = FW;
    for (int n = 0; n < 20; n++) begin
      step();
      if (rvalid && valid) begin
        id_ready = 1; hit = 1;
        break;
      end
    end
    step();
    checks += 2;
    if (!hit) begin
      errors++;
      $display("FAIL pp_setup got 0 want 1");
    end
    if (valid !== 1 || inst_addr !== 32'h204
        || inst !== mem(32'h204)) begin
      errors++;
      $display("FAIL pp_head got %b %h@%h want 1 %h@204",
               valid, inst, inst_addr, mem(32'h204));
    end
    quiesce();
  endtask

  task automatic test_jtag();
    pc = 32'h300; id_ready = 0; flow = FW;
    for (int n = 0; n < 20; n++) begin
      step();
      if (exp_q.size() == 2 && !req && !pending) break;
    end
    checks++;
    if (valid !== 1) begin
      errors++;
      $display("FAIL jtag_setup got %b want 1", valid);
    end
    jtag = 1;
    exp_q.delete();
    step();
    jtag = 0;
    checks++;
    if (valid !== 0) begin
      errors++;
      $display("FAIL jtag_flush got %b want 0", valid);
    end
    quiesce();
  endtask

  task automatic test_reset_mid();
    pc = 32'h400; rsp_delay = 4; id_ready = 1; flow = FW;
    for (int n = 0; n < 10 && gnt_q.size() < 1; n++) step();
    step();
    rst_n = 0;
    #1;
    checks++;
    if (req !== 0 || addr !== 0 || valid !== 0
        || inst !== 0 || inst_addr !== 0 || stall !== 1) begin
      errors++;
      $display("FAIL mid_reset got %b %h %b %h %h %b want 0 0 0 0 0 1",
               req, addr, valid, inst, inst_addr, stall);
    end
    exp_q.delete();
    step();
    rsp_delay = 1; pc = 32'h500;
    rst_n = 1;
    for (int n = 0; n < 20 && gnt_q.size() < 2; n++) step();
    checks++;
    if (gnt_q.size() < 2 || gnt_q[1] !== 32'h500) begin
      errors++;
      $display("FAIL post_reset got %0d grants want addr 500",
               gnt_q.size());
    end
    quiesce();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gnt_delay();
    test_backpressure();
    test_flush();
    test_same_cycle();
    test_jtag();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
